// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the 3x3 matrix mac datapath and
// the mac_sched request scheduler.
package mac_pkg;

    localparam int VAR_WIDTH         = 8;
    localparam int MAT_SIZE          = 3;
    localparam int DATA_WIDTH        = VAR_WIDTH * MAT_SIZE * MAT_SIZE;
    localparam int MAC_SCHED_MAX_REQ = 8;

    // Opcode 2'b11 is decoded as MUL as well (only bit 1 matters for MUL)
    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        MUL = 2'b10
    } mac_opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        EXEC,
        RESP
    } mac_sched_state_t;

    function automatic logic op_is_mul(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mac_rr_arb.sv
// mac_rr_arb: combinational round-robin arbiter. Searches req_i starting at
// ptr_i and wrapping at N-1; returns a one-hot grant and its index.
module mac_rr_arb #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    // First requester at or after the pointer wins
    always_comb begin : p_arb
        int idx;
        idx           = 0;
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_valid_o && req_i[idx]) begin
                grant_o[idx]  = 1'b1;
                grant_idx_o   = IDX_W'(idx);
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_sched.sv
// mac_sched: shares one 3x3 mac datapath among NUM_REQ requesters.
// Requests are arbitrated round-robin while idle; MUL ops get a one-cycle
// accumulator clear before the enable cycle. The result is returned with the
// owner's ID on a single response channel.
// Optional: define MAC_SCHED_PERF_EN to add perf_ops_o / perf_stall_o counters.
module mac_sched
    import mac_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [2*NUM_REQ-1:0]          req_opcode_i,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a_i,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [ID_W-1:0]               rsp_id_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          mac_enable_o,
    output logic                          mac_clr_o,
    output logic [1:0]                    mac_opcode_o,
    output logic [DATA_WIDTH-1:0]         mac_a_o,
    output logic [DATA_WIDTH-1:0]         mac_b_o,
    input  logic [DATA_WIDTH-1:0]         mac_result_i
`ifdef MAC_SCHED_PERF_EN
    ,
    output logic [15:0]                   perf_ops_o,
    output logic [15:0]                   perf_stall_o
`endif
);

    mac_sched_state_t      state_q;
    logic [ID_W-1:0]       rr_ptr_q;
    logic [ID_W-1:0]       rr_ptr_d;
    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [ID_W-1:0]       id_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_valid_q;
    logic                  mac_enable_q;
    logic                  mac_clr_q;

    logic [NUM_REQ-1:0]    gnt;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt_valid;
    logic                  accept;
    logic [1:0]            sel_op;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;

    mac_rr_arb #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req_i         (req_valid_i),
        .ptr_i         (rr_ptr_q),
        .grant_o       (gnt),
        .grant_idx_o   (gnt_idx),
        .grant_valid_o (gnt_valid)
    );

    // Grant is visible only while idle and out of reset; it completes the
    // handshake in the same cycle.
    assign accept      = (state_q == IDLE) && !rst_i && gnt_valid;
    assign req_ready_o = accept ? gnt : '0;

    assign sel_op   = req_opcode_i[2*gnt_idx +: 2];
    assign sel_a    = req_a_i[DATA_WIDTH*gnt_idx +: DATA_WIDTH];
    assign sel_b    = req_b_i[DATA_WIDTH*gnt_idx +: DATA_WIDTH];
    assign rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);

    // Main sequencing FSM; all mac control pins and response fields are registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            op_q         <= ADD;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            mac_enable_q <= 1'b0;
            mac_clr_q    <= 1'b1;
        end else begin
            mac_enable_q <= 1'b0;
            mac_clr_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q     <= sel_op;
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        id_q     <= gnt_idx;
                        rr_ptr_q <= rr_ptr_d;
                        if (op_is_mul(sel_op)) begin
                            state_q   <= CLR;
                            mac_clr_q <= 1'b1;
                        end else begin
                            state_q      <= EXEC;
                            mac_enable_q <= 1'b1;
                        end
                    end
                end
                CLR: begin
                    state_q      <= EXEC;
                    mac_enable_q <= 1'b1;
                end
                EXEC: begin
                    rsp_data_q  <= mac_result_i;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = id_q;
    assign rsp_data_o   = rsp_data_q;
    assign mac_enable_o = mac_enable_q;
    assign mac_clr_o    = mac_clr_q;
    assign mac_opcode_o = op_q;
    assign mac_a_o      = a_q;
    assign mac_b_o      = b_q;

`ifdef MAC_SCHED_PERF_EN
    logic [15:0] perf_ops_q;
    logic [15:0] perf_stall_q;

    // Saturating counters of completed responses and stalled response cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else if (state_q == RESP) begin
            if (rsp_ready_i && perf_ops_q != 16'hFFFF) begin
                perf_ops_q <= perf_ops_q + 16'd1;
            end
            if (!rsp_ready_i && perf_stall_q != 16'hFFFF) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign perf_ops_o   = perf_ops_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: doc/mac_sched.md
Name: mac_sched

Overview:
- Round-robin scheduler that shares one `mac` 3x3 matrix datapath between NUM_REQ requesters.
- Each requester issues {opcode, A, B} over a valid/ready handshake.
- The block sequences the `mac` control pins (clr/enable/opcode) and captures result_o.
- It returns the result with the requester ID over a single shared response channel.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ) (min 1), response ID width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
- req_opcode_i  in  2*NUM_REQ  opcode per requester, slice r at [2r+1:2r]
- req_a_i  in  DATA_WIDTH*NUM_REQ  flattened matrix A per requester
- req_b_i  in  DATA_WIDTH*NUM_REQ  flattened matrix B per requester
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accept
- rsp_id_o  out  ID_W  index of the requester that owns the response
- rsp_data_o  out  DATA_WIDTH  result matrix
- mac_enable_o  out  1  to mac enable_i
- mac_clr_o  out  1  to mac clr_i
- mac_opcode_o  out  2  to mac opcode_i
- mac_a_o  out  DATA_WIDTH  to mac matrixA_i
- mac_b_o  out  DATA_WIDTH  to mac matrixB_i
- mac_result_i  in  DATA_WIDTH  from mac result_o

Behaviour:
- Single clock clk_i; rst_i synchronous, active-high, highest priority.
- Reset values:
  - state=IDLE, rr_ptr=0
  - req_ready_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0
  - mac_enable_o=0, mac_clr_o=1 (clears the mac accumulator during reset), mac_opcode_o=ADD, mac_a_o=0, mac_b_o=0
- FSM states: IDLE, CLR, EXEC, RESP.
- IDLE:
  - Arbitrate among req_valid_i, round-robin starting at rr_ptr.
  - Winner w gets req_ready_o[w]=1 combinationally in that same cycle. Handshake completes immediately.
  - On handshake: latch opcode/A/B/id into operand registers and set rr_ptr = (w+1) mod NUM_REQ.
  - Next state: CLR if opcode is MUL (2'b10 or 2'b11), else EXEC.
  - No valid request: stay in IDLE, req_ready_o=0.
- CLR (MUL only, 1 cycle):
  - mac_clr_o=1, mac_enable_o=0, mac operands driven from the operand registers. Next state EXEC.
- EXEC (1 cycle):
  - mac_clr_o=0, mac_enable_o=1, mac_opcode_o/mac_a_o/mac_b_o from the operand registers.
  - Capture mac_result_i into rsp_data_o at the clock edge. Next state RESP.
  - MUL result = 0 + A x B, modulo 2^VAR_WIDTH per element. ADD/SUB wrap modulo 2^VAR_WIDTH.
- RESP:
  - rsp_valid_o=1; rsp_id_o and rsp_data_o held stable until rsp_ready_i=1.
  - On handshake: go to IDLE, with rsp_valid_o low from the next cycle.
  - No request is accepted while in RESP (req_ready_o=0).
- Outside EXEC: mac_enable_o=0. Outside CLR and reset: mac_clr_o=0.
- Latency from request handshake to rsp_valid_o: ADD/SUB 2 cycles, MUL 3 cycles.
- Throughput: one op per 3 cycles (ADD/SUB) or 4 cycles (MUL) with rsp_ready_i tied high.
- Boundary cases:
  - req_valid_i dropped before grant: no side effect.
  - rsp_ready_i high in the same cycle rsp_valid_o rises: completes immediately.
  - rr_ptr wraps NUM_REQ-1 -> 0.
  - Only one requester active: it is granted every IDLE cycle.
  - rst_i asserted mid-operation: any state returns to IDLE next cycle; the in-flight op is dropped with no response.

Optional Feature:
- MAC_SCHED_PERF_EN defined:
  - Adds output perf_ops_o [15:0], count of completed responses.
  - Adds output perf_stall_o [15:0], count of RESP cycles with rsp_ready_i=0.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- mac_pkg gains:
  - typedef enum {IDLE, CLR, EXEC, RESP} mac_sched_state_t
  - localparam MAC_SCHED_MAX_REQ=8
- Reuse existing DATA_WIDTH, VAR_WIDTH, MAT_SIZE and the ADD/SUB/MUL opcode enum.
- One natural sub-module: mac_rr_arb, a parameterised round-robin arbiter. Inputs: req vector, pointer. Outputs: one-hot grant and grant index.

Test Plan:
- Reset, then req0 ADD with A=all 8'h01, B=all 8'h02 -> after 2 cycles rsp_valid_o=1, rsp_id_o=0, rsp_data_o=72'h030303030303030303.
- req1 SUB with A=all 8'h01, B=all 8'h02 -> rsp_data_o=all 8'hFF (wrap), rsp_id_o=1.
- req0 MUL with A=identity (72'h010000000100000001), B=72'h010203040506070809 -> mac_clr_o pulses one cycle before EXEC; rsp_data_o=B; latency 3.
- Both requesters valid continuously, rsp_ready_i=1 -> grants alternate 0,1,0,1; rsp_id_o sequence matches.
- rsp_ready_i held low 5 cycles in RESP -> rsp_data_o/rsp_id_o stable; req_ready_o=0 throughout; completes on rsp_ready_i=1.
- rst_i asserted during EXEC of a MUL -> next cycle IDLE, rsp_valid_o=0, mac_clr_o=1 during reset; the subsequent request is served correctly from rr_ptr=0.
